pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  - Selects the forwarding sources for the ID-stage operands.
//  - Detects load-use hazards and inserts bubbles.
//  - Flushes IF/ID on a taken branch when delay slots are disabled.
//  - Runs the data-memory wait-state handshake, freezing the pipeline registers while the M stage waits.
//  - Keeps a stall-cycle performance counter and a sticky bus-timeout error.
// PARAMETERS
//  MAX_WAIT    16  cycles in WAIT without dmem_ready before timeout (>=2)
//  DELAY_SLOT  1   1: taken branch has one delay slot (no flush); 0: flush IF/ID
//  CNT_W       16  width of stall_cnt
// PORTS
//  clock       in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  rs, rt      in   5      ID-stage source register numbers
//  use_rs      in   1      ID instruction reads rs
//  use_rt      in   1      ID instruction reads rt
//  br_taken    in   1      ID-stage branch/jump resolved taken
//  ewreg       in   1      EX-stage instruction writes the register file
//  em2reg      in   1      EX-stage instruction is a load
//  ern         in   5      EX-stage destination register
//  mwreg       in   1      MEM-stage instruction writes the register file
//  mm2reg      in   1      MEM-stage instruction is a load
//  mrn         in   5      MEM-stage destination register
//  mmem        in   1      MEM-stage instruction is a load or store
//  dmem_ready  in   1      data memory completes the access this cycle
//  dmem_req    out  1      data-memory access request
//  fwda, fwdb  out  2      operand source: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM mem-out
//  pc_en       out  1      PC write enable
//  fd_en       out  1      IF/ID register write enable
//  fd_nop      out  1      IF/ID loads a bubble
//  de_en       out  1      ID/EX register write enable
//  de_nop      out  1      ID/EX loads a bubble
//  em_en       out  1      EX/MEM register write enable
//  mw_nop      out  1      MEM/WB loads a bubble (wreg = 0)
//  bus_err     out  1      sticky memory-timeout flag
//  stall_cnt   out  CNT_W  count of cycles with pc_en = 0, saturating
// BEHAVIOUR
//  Reset (async; state held while high)
//  - state = IDLE, wait_cnt = 0, bus_err = 0, stall_cnt = 0.
//  - With all inputs 0: enables = 1, nops = 0, fwd = 00, dmem_req = 0.
//  Forwarding (combinational, per operand; rs shown, rt identical)
//  - Register number 0 never matches.
//  - EX match has priority over MEM match.
//  - 01 if ewreg & ~em2reg & ern == rs.
//  - Else 10 if mwreg & ~mm2reg & mrn == rs.
//  - Else 11 if mwreg & mm2reg & mrn == rs.
//  - Else 00.
//  Load-use hazard (lu)
//  - lu = ewreg & em2reg & ern != 0 & ((use_rs & ern == rs) | (use_rt & ern == rt)).
//  - Response: pc_en = 0, fd_en = 0, de_nop = 1. EX/MEM and MEM/WB advance.
//  Branch flush
//  - Applies only when DELAY_SLOT = 0: br_taken & ~lu & ~mstall -> fd_nop = 1.
//  - No flush while lu is active (branch operands are not valid that cycle).
//  Memory FSM (states IDLE, WAIT, ERR)
//  - IDLE: dmem_req = mmem.
//    - mmem & dmem_ready: zero-wait access, no stall.
//    - mmem & ~dmem_ready: -> WAIT, wait_cnt = 1.
//  - WAIT: dmem_req = 1.
//    - dmem_ready: -> IDLE; the pipeline advances this same cycle.
//    - Else, wait_cnt == MAX_WAIT - 1: -> ERR, bus_err <= 1.
//    - Else wait_cnt increments.
//  - ERR: dmem_req = 0; exits only by reset.
//  - mstall = (IDLE & mmem & ~dmem_ready) | (WAIT & ~dmem_ready) | ERR.
//  - Response: pc_en = fd_en = de_en = em_en = 0, mw_nop = 1.
//  - fd_nop = de_nop = 0 (freeze, not bubble).
//  - mstall overrides lu and the branch flush.
//  stall_cnt
//  - Increments each cycle pc_en = 0.
//  - Saturates at 2^CNT_W - 1 (no wrap).
//  Reset mid-WAIT
//  - Returns to IDLE immediately; dmem_req drops asynchronously.
// TESTING
//  1) Forwarding: rs=3,use_rs=1,ewreg=1,em2reg=0,ern=3 -> fwda=01.
//     Same with ern=0 -> fwda=00.
//     Add mwreg=1,mm2reg=1,mrn=3 with ewreg=0 -> fwda=11.
//  2) Load-use: em2reg=ewreg=1,ern=5,rt=5,use_rt=1.
//     -> pc_en=0,fd_en=0,de_nop=1,em_en=1 for exactly 1 cycle.
//     -> stall_cnt 0->1.
//  3) Wait states: mmem=1, dmem_ready low for 3 cycles then high.
//     -> dmem_req high 4 cycles, mstall 3 cycles, state IDLE after.
//     -> stall_cnt=3.
//  4) Timeout: MAX_WAIT=16, dmem_ready held 0.
//     -> bus_err=1 after 16 cycles of mstall, pipeline frozen.
//     -> cleared only by reset.
//  5) Priority: mstall with lu and br_taken (DELAY_SLOT=0) in the same cycle.
//     -> de_nop=0, fd_nop=0, all enables 0.
//     -> after ready: lu bubble on the next cycle.
//  6) Reset asserted in WAIT (wait_cnt=7).
//     -> dmem_req=0, state IDLE, stall_cnt=0 without a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and stall controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   - Selects forwarding sources for the two ID-stage operands.
//   - Detects load-use hazards and inserts a bubble into ID/EX.
//   - Flushes IF/ID on a taken branch when delay slots are disabled.
//   - Runs the data-memory wait-state handshake (IDLE/WAIT/ERR) and freezes
//     the pipeline registers while the MEM stage waits.
//   - Keeps a saturating stall-cycle counter and a sticky bus-timeout flag.
//
// Parameters
//   MAX_WAIT    cycles without dmem_ready before a bus timeout (>= 2)
//   DELAY_SLOT  1: taken branch has one delay slot; 0: flush IF/ID
//   CNT_W       width of stall_cnt
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   rs, rt, use_rs/rt     ID-stage sources and their read enables
//   br_taken              ID-stage branch/jump resolved taken
//   ewreg, em2reg, ern    EX-stage write enable, load flag, destination
//   mwreg, mm2reg, mrn    MEM-stage write enable, load flag, destination
//   mmem, dmem_ready      MEM-stage memory access, memory completion
//   dmem_req              data-memory request
//   fwda, fwdb            00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data
//   pc_en, fd_en, de_en, em_en      pipeline register write enables
//   fd_nop, de_nop, mw_nop          bubble inserts
//   bus_err               sticky memory-timeout flag
//   stall_cnt             saturating count of cycles with pc_en = 0
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT   = 16,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             br_taken,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic             mmem,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_nop,
  output logic             de_en,
  output logic             de_nop,
  output logic             em_en,
  output logic             mw_nop,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // wait_cnt only ever holds 0 .. MAX_WAIT-1
  localparam int unsigned WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [WCNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic              bus_err_q,   bus_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu;
  logic mstall;

  // ---------------------------------------------------------------------------
  // Forwarding: EX result wins over MEM; r0 is hard-wired zero and never
  // forwarded. A load in EX has no data yet, so it is not a forwarding source
  // (the load-use stall covers that case).
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (r != 5'd0) begin
      if (ewreg && !em2reg && (ern == r))  sel = 2'b01;
      else if (mwreg && (mrn == r))        sel = mm2reg ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  assign fwda = fwd_sel(rs);
  assign fwdb = fwd_sel(rt);

  // Load-use: the EX load's data is not available until after MEM.
  assign lu = ewreg && em2reg && (ern != 5'd0) &&
              ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

  // ---------------------------------------------------------------------------
  // Memory handshake. A WAIT cycle that sees dmem_ready releases the pipeline
  // in that same cycle, so it is not a stall cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    dmem_req   = 1'b0;
    mstall     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dmem_req = mmem;
        if (mmem && !dmem_ready) begin
          mstall     = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mstall     = 1'b1;
          state_d    = S_ERR;
          wait_cnt_d = '0;
          bus_err_d  = 1'b1;
        end else begin
          mstall     = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      S_ERR: begin
        // Dead bus: stay frozen until reset.
        mstall = 1'b1;
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline control. A memory stall freezes everything in place (no bubbles)
  // and overrides both the load-use bubble and the branch flush.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en  = !(mstall || lu);
    fd_en  = !(mstall || lu);
    de_en  = !mstall;
    em_en  = !mstall;
    de_nop = lu && !mstall;
    mw_nop = mstall;
    // Branch operands are not valid while lu holds ID, so no flush then.
    fd_nop = (DELAY_SLOT == 1'b0) && br_taken && !lu && !mstall;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two controllers share all inputs:
//     u0: MAX_WAIT=16, DELAY_SLOT=0, CNT_W=16
//     u1: MAX_WAIT=4,  DELAY_SLOT=1, CNT_W=4  (short timeout, early saturation)
//   The reference model tracks, per instance, how many consecutive cycles the
//   current memory access has been left waiting, a dead-bus flag and the stall
//   count, and derives every output from the behavioural rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs, rt, ern, mrn;
  logic       use_rs, use_rt, br_taken, ewreg, em2reg, mwreg, mm2reg;
  logic       mmem, dmem_ready;

  logic        dmem_req0, pc_en0, fd_en0, fd_nop0, de_en0, de_nop0, em_en0, mw_nop0, bus_err0;
  logic [1:0]  fwda0, fwdb0;
  logic [15:0] cnt0;
  logic        dmem_req1, pc_en1, fd_en1, fd_nop1, de_en1, de_nop1, em_en1, mw_nop1, bus_err1;
  logic [1:0]  fwda1, fwdb1;
  logic [3:0]  cnt1;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .DELAY_SLOT(1'b0), .CNT_W(16)) u0 (
    .clock(clock), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .br_taken(br_taken), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg),
    .mm2reg(mm2reg), .mrn(mrn), .mmem(mmem), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req0), .fwda(fwda0), .fwdb(fwdb0), .pc_en(pc_en0), .fd_en(fd_en0),
    .fd_nop(fd_nop0), .de_en(de_en0), .de_nop(de_nop0), .em_en(em_en0), .mw_nop(mw_nop0),
    .bus_err(bus_err0), .stall_cnt(cnt0));

  pipe_hazard_ctrl #(.MAX_WAIT(4), .DELAY_SLOT(1'b1), .CNT_W(4)) u1 (
    .clock(clock), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .br_taken(br_taken), .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg),
    .mm2reg(mm2reg), .mrn(mrn), .mmem(mmem), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req1), .fwda(fwda1), .fwdb(fwdb1), .pc_en(pc_en1), .fd_en(fd_en1),
    .fd_nop(fd_nop1), .de_en(de_en1), .de_nop(de_nop1), .em_en(em_en1), .mw_nop(mw_nop1),
    .bus_err(bus_err1), .stall_cnt(cnt1));

  // Observed outputs, one row per instance, same field order as names[].
  logic [15:0] o [2][12];
  always_comb begin
    o[0][0] = {15'd0, dmem_req0}; o[0][1] = {14'd0, fwda0};  o[0][2]  = {14'd0, fwdb0};
    o[0][3] = {15'd0, pc_en0};    o[0][4] = {15'd0, fd_en0}; o[0][5]  = {15'd0, fd_nop0};
    o[0][6] = {15'd0, de_en0};    o[0][7] = {15'd0, de_nop0}; o[0][8] = {15'd0, em_en0};
    o[0][9] = {15'd0, mw_nop0};   o[0][10] = {15'd0, bus_err0}; o[0][11] = cnt0;
    o[1][0] = {15'd0, dmem_req1}; o[1][1] = {14'd0, fwda1};  o[1][2]  = {14'd0, fwdb1};
    o[1][3] = {15'd0, pc_en1};    o[1][4] = {15'd0, fd_en1}; o[1][5]  = {15'd0, fd_nop1};
    o[1][6] = {15'd0, de_en1};    o[1][7] = {15'd0, de_nop1}; o[1][8] = {15'd0, em_en1};
    o[1][9] = {15'd0, mw_nop1};   o[1][10] = {15'd0, bus_err1}; o[1][11] = {12'd0, cnt1};
  end

  string names [12] = '{"dmem_req", "fwda", "fwdb", "pc_en", "fd_en", "fd_nop",
                        "de_en", "de_nop", "em_en", "mw_nop", "bus_err", "stall_cnt"};

  int unsigned tests = 0;
  int unsigned fails = 0;

  // ---------------- reference model ----------------
  int unsigned m_waited [2];   // cycles the current access has waited
  bit          m_dead   [2];   // bus timed out
  int unsigned m_cnt    [2];   // stall cycles

  function automatic int unsigned max_wait(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int unsigned cnt_max(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  function automatic bit has_delay_slot(input int i);
    return (i == 1);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (ewreg && !em2reg && ern == r) return 2'd1;
    if (mwreg && mrn == r) return mm2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic bit exp_lu();
    return ewreg && em2reg && ern != 0 &&
           ((use_rs && ern == rs) || (use_rt && ern == rt));
  endfunction

  function automatic bit exp_req(input int i);
    if (m_dead[i]) return 1'b0;
    if (m_waited[i] > 0) return 1'b1;
    return mmem;
  endfunction

  function automatic bit exp_mstall(input int i);
    return m_dead[i] || (exp_req(i) && !dmem_ready);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_waited[i] = 0;
      m_dead[i]   = 1'b0;
      m_cnt[i]    = 0;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      bit ms, stall;
      ms    = exp_mstall(i);
      stall = ms || exp_lu();
      if (stall && m_cnt[i] < cnt_max(i)) m_cnt[i]++;
      if (!m_dead[i]) begin
        if (ms) begin
          m_waited[i]++;
          if (m_waited[i] == max_wait(i)) begin
            m_dead[i]   = 1'b1;
            m_waited[i] = 0;
          end
        end else begin
          m_waited[i] = 0;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] e [12];
      bit ms, lu;
      ms = exp_mstall(i);
      lu = exp_lu();
      e[0]  = 16'(exp_req(i));
      e[1]  = 16'(exp_fwd(rs));
      e[2]  = 16'(exp_fwd(rt));
      e[3]  = 16'(!(ms || lu));
      e[4]  = 16'(!(ms || lu));
      e[5]  = 16'(!has_delay_slot(i) && br_taken && !lu && !ms);
      e[6]  = 16'(!ms);
      e[7]  = 16'(lu && !ms);
      e[8]  = 16'(!ms);
      e[9]  = 16'(ms);
      e[10] = 16'(m_dead[i]);
      e[11] = 16'(m_cnt[i]);
      for (int k = 0; k < 12; k++)
        check($sformatf("u%0d.%s", i, names[k]), o[i][k], e[k]);
    end
  endtask

  // Inputs are stable from posedge+1; check at negedge, advance model at posedge.
  task automatic cycle();
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic clear_inputs();
    rs = 0; rt = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0; br_taken = 0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
    mmem = 0; dmem_ready = 0;
  endtask

  // Asserts reset between clock edges, holds it across one edge, releases it.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clock);
    #1 check_all();
    #2 reset = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    model_reset();

    // Reset state, all inputs 0.
    #3;
    check_all();
    check("reset.pc_en", {15'd0, pc_en0}, 16'd1);
    check("reset.dmem_req", {15'd0, dmem_req0}, 16'd0);
    check("reset.stall_cnt", cnt0, 16'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;

    // Forwarding.
    rs = 3; use_rs = 1; ewreg = 1; ern = 3;
    cycle();
    check("fwd.ex", {14'd0, fwda0}, 16'd1);
    ern = 0;
    cycle();
    check("fwd.r0", {14'd0, fwda0}, 16'd0);
    ewreg = 0; mwreg = 1; mm2reg = 1; mrn = 3;
    cycle();
    check("fwd.memload", {14'd0, fwda0}, 16'd3);
    mm2reg = 0; rt = 3;
    cycle();
    check("fwd.memalu_b", {14'd0, fwdb0}, 16'd2);

    // Load-use bubble: one cycle, then the load moves on.
    clear_inputs();
    ewreg = 1; em2reg = 1; ern = 5; rt = 5; use_rt = 1;
    cycle();
    check("lu.stall_cnt", cnt0, 16'd1);
    clear_inputs();
    cycle();
    check("lu.released", {15'd0, pc_en0}, 16'd1);

    // Branch flush alone: u0 flushes, u1 keeps the delay slot.
    br_taken = 1;
    cycle();
    check("br.flush_u0", {15'd0, fd_nop0}, 16'd1);
    check("br.slot_u1", {15'd0, fd_nop1}, 16'd0);
    br_taken = 0;

    // Three wait states, then ready.
    mmem = 1; dmem_ready = 0;
    repeat (3) cycle();
    dmem_ready = 1;
    cycle();
    check("wait.stall_cnt", cnt0, 16'd4);
    mmem = 0;
    cycle();

    // Timeout: 16 stalled cycles kill u0's bus (u1 dies after 4).
    mmem = 1; dmem_ready = 0;
    repeat (15) cycle();
    check("timeout.before", {15'd0, bus_err0}, 16'd0);
    cycle();
    check("timeout.bus_err", {15'd0, bus_err0}, 16'd1);
    dmem_ready = 1; mmem = 0;
    repeat (4) cycle();
    check("timeout.frozen", {15'd0, em_en0}, 16'd0);
    check("sat.u1", {12'd0, cnt1}, 16'd15);
    async_reset();
    check("timeout.cleared", {15'd0, bus_err0}, 16'd0);

    // Memory stall together with load-use and a taken branch.
    clear_inputs();
    mmem = 1; ewreg = 1; em2reg = 1; ern = 5; rt = 5; use_rt = 1; br_taken = 1;
    cycle();
    check("prio.de_nop", {15'd0, de_nop0}, 16'd0);
    check("prio.fd_nop", {15'd0, fd_nop0}, 16'd0);
    check("prio.de_en", {15'd0, de_en0}, 16'd0);
    dmem_ready = 1;
    cycle();
    check("prio.lu_after", {15'd0, de_nop0}, 16'd1);
    clear_inputs();
    cycle();

    // Reset while u0 sits in WAIT with wait_cnt = 7.
    mmem = 1;
    repeat (7) cycle();
    mmem = 0;
    check("rstwait.req_held", {15'd0, dmem_req0}, 16'd1);
    #2 reset = 1'b1;
    #1 model_reset();
    check("rstwait.req", {15'd0, dmem_req0}, 16'd0);
    check("rstwait.cnt", cnt0, 16'd0);
    check_all();
    @(posedge clock);
    #2 reset = 1'b0;
    #1;

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      rs = 5'($urandom_range(0, 3));  rt = 5'($urandom_range(0, 3));
      ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
      use_rs = 1'($urandom); use_rt = 1'($urandom); br_taken = 1'($urandom);
      ewreg = 1'($urandom); em2reg = 1'($urandom);
      mwreg = 1'($urandom); mm2reg = 1'($urandom);
      mmem = ($urandom_range(0, 9) < 3);
      dmem_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 149) == 0) async_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
